pic_control_logic: RTL and testbench

Clocked control stage of the 8259-style PIC, directly downstream of the read/write logic. Consumes the command-type flag, command byte and read selector that stage produces. Owns IMR, ISR, priority rotation and the INTA acknowledge sequence. Drives INT, the vector byte and IRR-clear pulses back to the IRR block.

---
 rtl/pic_control_logic.sv | 239 +++++++++++++++++++++++
 tb/tb_pic_control_logic.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/pic_control_logic.sv
// pic_control_logic
//   Clocked control stage of an 8259-style PIC. Holds the mask and in-service
//   registers, resolves priority (fixed or rotating), and runs the two-pulse
//   INTA acknowledge sequence. Optional rotation commands are compiled in with
//   the PIC_ROTATE_EN macro; without it priority is fixed (IR0 highest).
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   wr_strobe/flag/cmd_data   command write (flag: 0..3 ICW1..4, 4..6 OCW1..3)
//   rd_strobe/read_sel  register read (011 IMR, 101 ISR, others IRR)
//   irr                 interrupt requests from the IRR block
//   inta_n              acknowledge, active-low, synchronous to clk
//   int_out             interrupt request to the CPU
//   irr_clr             one-hot one-cycle pulse clearing the acknowledged IRR bit
//   data_out/data_oe    read data or vector byte, with valid flag
//   ready               initialisation complete
module pic_control_logic (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       wr_strobe,
   input  logic [2:0] flag,
   input  logic [7:0] cmd_data,
   input  logic       rd_strobe,
   input  logic [2:0] read_sel,
   input  logic [7:0] irr,
   input  logic       inta_n,
   output logic       int_out,
   output logic [7:0] irr_clr,
   output logic [7:0] data_out,
   output logic       data_oe,
   output logic       ready
);

   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_INT = 2'd1, ST_ACK1 = 2'd2, ST_ACK2 = 2'd3} state_t;

   // Returns {found, level} of the first set bit scanning upward from lowest+1.
   function automatic logic [3:0] first_in_order(input logic [7:0] vec, input logic [2:0] lowest);
      logic [3:0] res;
      logic [2:0] lvl;
      res = 4'd0;
      for (int i = 7; i >= 0; i--) begin
         lvl = lowest + 3'd1 + 3'(i);
         if (vec[lvl]) res = {1'b1, lvl};
      end
      return res;
   endfunction

   // Position in the priority order; 0 is the highest priority.
   function automatic logic [2:0] rank(input logic [2:0] lvl, input logic [2:0] lowest);
      return lvl - lowest - 3'd1;
   endfunction

   function automatic logic [7:0] onehot(input logic [2:0] lvl);
      return 8'd1 << lvl;
   endfunction

   // Only the ICW fields this stage uses are kept.
   logic       icw1_sngl_r, icw1_ic4_r, icw4_aeoi_r;
   logic [4:0] icw2_base_r;
   logic [7:0] imr_r, isr_r;
   logic [2:0] lowest_pri_r, vec_lvl_r;
   logic       inta_prev_r;
   state_t     state_r;
`ifdef PIC_ROTATE_EN
   logic       rot_aeoi_r;
   logic       rot_upd_s, rot_aeoi_set_s, rot_aeoi_clr_s;
   logic [2:0] rot_lvl_s;
`endif

   logic [7:0] req_s, isr_set_s, isr_clr_ocw_s, aeoi_clr_s, isr_next_s;
   logic [3:0] win_s, isr_top_s;
   logic       pending_s, inta_fall_s, ack_take_s, aeoi_s, icw1_wr_s, ocw2_wr_s;

   assign icw1_wr_s   = wr_strobe && (flag == 3'd0);
   assign ocw2_wr_s   = wr_strobe && (flag == 3'd5);
   assign req_s       = irr & ~imr_r;
   assign win_s       = first_in_order(req_s, lowest_pri_r);
   assign isr_top_s   = first_in_order(isr_r, lowest_pri_r);
   assign pending_s   = ready && win_s[3] &&
                        (!isr_top_s[3] || (rank(win_s[2:0], lowest_pri_r) < rank(isr_top_s[2:0], lowest_pri_r)));
   assign inta_fall_s = !inta_n && inta_prev_r;
   assign ack_take_s  = (state_r == ST_INT) && inta_fall_s;
   assign aeoi_s      = (state_r == ST_ACK2) && inta_n && icw4_aeoi_r;
   assign isr_set_s   = (ack_take_s && win_s[3]) ? onehot(win_s[2:0]) : 8'd0;
   assign aeoi_clr_s  = aeoi_s ? onehot(vec_lvl_r) : 8'd0;
   // Set is applied after clear so a coincident set of the same bit wins.
   assign isr_next_s  = (isr_r & ~(isr_clr_ocw_s | aeoi_clr_s)) | isr_set_s;

   // OCW2 decode: EOI clears and, when enabled, rotation updates.
   always_comb begin
      isr_clr_ocw_s = 8'd0;
`ifdef PIC_ROTATE_EN
      rot_upd_s      = 1'b0;
      rot_lvl_s      = lowest_pri_r;
      rot_aeoi_set_s = 1'b0;
      rot_aeoi_clr_s = 1'b0;
`endif
      if (ocw2_wr_s) begin
         case (cmd_data[7:5])
            3'b001: isr_clr_ocw_s = isr_top_s[3] ? onehot(isr_top_s[2:0]) : 8'd0;
            3'b011: isr_clr_ocw_s = onehot(cmd_data[2:0]);
`ifdef PIC_ROTATE_EN
            3'b101: begin
               if (isr_top_s[3]) begin
                  isr_clr_ocw_s = onehot(isr_top_s[2:0]);
                  rot_upd_s     = 1'b1;
                  rot_lvl_s     = isr_top_s[2:0];
               end else begin
                  isr_clr_ocw_s = 8'd0;
               end
            end
            3'b111: begin
               isr_clr_ocw_s = onehot(cmd_data[2:0]);
               rot_upd_s     = 1'b1;
               rot_lvl_s     = cmd_data[2:0];
            end
            3'b110: begin
               rot_upd_s = 1'b1;
               rot_lvl_s = cmd_data[2:0];
            end
            3'b100: rot_aeoi_set_s = 1'b1;
            3'b000: rot_aeoi_clr_s = 1'b1;
`else
            3'b101: isr_clr_ocw_s = isr_top_s[3] ? onehot(isr_top_s[2:0]) : 8'd0;
            3'b111: isr_clr_ocw_s = onehot(cmd_data[2:0]);
`endif
            default: isr_clr_ocw_s = 8'd0;
         endcase
      end else begin
         isr_clr_ocw_s = 8'd0;
      end
   end

   // Configuration, mask, in-service, priority and ready registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         icw1_sngl_r  <= 1'b0;
         icw1_ic4_r   <= 1'b0;
         icw2_base_r  <= 5'd0;
         icw4_aeoi_r  <= 1'b0;
         imr_r        <= 8'd0;
         isr_r        <= 8'd0;
         lowest_pri_r <= 3'd7;
         ready        <= 1'b0;
`ifdef PIC_ROTATE_EN
         rot_aeoi_r   <= 1'b0;
`endif
      end else if (icw1_wr_s) begin
         icw1_sngl_r  <= cmd_data[1];
         icw1_ic4_r   <= cmd_data[0];
         icw4_aeoi_r  <= 1'b0;
         imr_r        <= 8'd0;
         isr_r        <= 8'd0;
         lowest_pri_r <= 3'd7;
         ready        <= 1'b0;
`ifdef PIC_ROTATE_EN
         rot_aeoi_r   <= 1'b0;
`endif
      end else begin
         if (wr_strobe) begin
            case (flag)
               3'd1: begin
                  icw2_base_r <= cmd_data[7:3];
                  if (icw1_sngl_r && !icw1_ic4_r) ready <= 1'b1;
               end
               3'd2: if (!icw1_ic4_r) ready <= 1'b1;
               3'd3: begin
                  icw4_aeoi_r <= cmd_data[1];
                  ready       <= 1'b1;
               end
               3'd4: imr_r <= cmd_data;
               default: imr_r <= imr_r;
            endcase
         end
         isr_r <= isr_next_s;
`ifdef PIC_ROTATE_EN
         if (rot_aeoi_set_s) rot_aeoi_r <= 1'b1;
         else if (rot_aeoi_clr_s) rot_aeoi_r <= 1'b0;
         if (rot_upd_s) lowest_pri_r <= rot_lvl_s;
         else if (aeoi_s && rot_aeoi_r) lowest_pri_r <= vec_lvl_r;
`endif
      end
   end

   // Acknowledge FSM with registered int_out, irr_clr and data bus outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= ST_IDLE;
         inta_prev_r <= 1'b1;
         vec_lvl_r   <= 3'd0;
         int_out     <= 1'b0;
         irr_clr     <= 8'd0;
         data_out    <= 8'd0;
         data_oe     <= 1'b0;
      end else begin
         inta_prev_r <= inta_n;
         irr_clr     <= 8'd0;
         data_oe     <= 1'b0;
         if (rd_strobe) begin
            data_oe <= 1'b1;
            case (read_sel)
               3'b011:  data_out <= imr_r;
               3'b101:  data_out <= isr_r;
               default: data_out <= irr;
            endcase
         end
         if (icw1_wr_s) begin
            state_r <= ST_IDLE;
            int_out <= 1'b0;
         end else begin
            case (state_r)
               ST_IDLE: if (pending_s) begin
                  state_r <= ST_INT;
                  int_out <= 1'b1;
               end
               ST_INT: if (ack_take_s) begin
                  state_r   <= ST_ACK1;
                  int_out   <= 1'b0;
                  irr_clr   <= isr_set_s;
                  // Spurious acknowledge reports level 7.
                  vec_lvl_r <= win_s[3] ? win_s[2:0] : 3'd7;
               end
               ST_ACK1: if (inta_fall_s) begin
                  state_r  <= ST_ACK2;
                  data_oe  <= 1'b1;
                  data_out <= {icw2_base_r, vec_lvl_r};
               end
               ST_ACK2: if (inta_n) begin
                  state_r <= ST_IDLE;
               end else begin
                  data_oe  <= 1'b1;
                  data_out <= {icw2_base_r, vec_lvl_r};
               end
               default: state_r <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_pic_control_logic.sv
module tb_pic_control_logic;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       wr_strobe = 1'b0;
   logic [2:0] flag = 3'd0;
   logic [7:0] cmd_data = 8'd0;
   logic       rd_strobe = 1'b0;
   logic [2:0] read_sel = 3'd0;
   logic [7:0] irr = 8'd0;
   logic       inta_n = 1'b1;
   logic       int_out, data_oe, ready;
   logic [7:0] irr_clr, data_out;
   int checks = 0;
   int failures = 0;
   logic [7:0] vec;
   logic       voe;

   pic_control_logic dut (
      .clk(clk), .rst_n(rst_n), .wr_strobe(wr_strobe), .flag(flag), .cmd_data(cmd_data),
      .rd_strobe(rd_strobe), .read_sel(read_sel), .irr(irr), .inta_n(inta_n),
      .int_out(int_out), .irr_clr(irr_clr), .data_out(data_out), .data_oe(data_oe), .ready(ready)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_cmd(input logic [2:0] f, input logic [7:0] d);
      wr_strobe = 1'b1; flag = f; cmd_data = d;
      tick();
      wr_strobe = 1'b0;
   endtask

   task automatic read_reg(input logic [2:0] s);
      rd_strobe = 1'b1; read_sel = s;
      tick();
      rd_strobe = 1'b0;
   endtask

   task automatic init_pic(input logic [7:0] icw4);
      write_cmd(3'd0, 8'h13);
      write_cmd(3'd1, 8'h20);
      write_cmd(3'd3, icw4);
   endtask

   // Full two-pulse acknowledge; returns the byte on the bus during the second pulse.
   task automatic do_ack(output logic [7:0] v, output logic oe);
      inta_n = 1'b0; tick();
      inta_n = 1'b1; tick();
      inta_n = 1'b0; tick();
      v = data_out; oe = data_oe;
      inta_n = 1'b1; tick();
   endtask

   task automatic test_reset();
      rst_n = 1'b0; tick(); tick();
      checks++; if (int_out !== 1'b0) begin failures++; $display("FAIL rst_int: got %b exp 0", int_out); end
      checks++; if (irr_clr !== 8'h00) begin failures++; $display("FAIL rst_irr_clr: got %h exp 00", irr_clr); end
      checks++; if (data_out !== 8'h00) begin failures++; $display("FAIL rst_data: got %h exp 00", data_out); end
      checks++; if (data_oe !== 1'b0) begin failures++; $display("FAIL rst_oe: got %b exp 0", data_oe); end
      checks++; if (ready !== 1'b0) begin failures++; $display("FAIL rst_ready: got %b exp 0", ready); end
      rst_n = 1'b1; tick();
   endtask

   task automatic test_init_ack();
      irr = 8'h04;
      init_pic(8'h01);
      checks++; if (ready !== 1'b1) begin failures++; $display("FAIL init_ready: got %b exp 1", ready); end
      tick();
      checks++; if (int_out !== 1'b1) begin failures++; $display("FAIL init_int: got %b exp 1", int_out); end
      inta_n = 1'b0; tick();
      checks++; if (irr_clr !== 8'h04) begin failures++; $display("FAIL ack1_irr_clr: got %h exp 04", irr_clr); end
      checks++; if (int_out !== 1'b0) begin failures++; $display("FAIL ack1_int: got %b exp 0", int_out); end
      inta_n = 1'b1; irr = 8'h00; tick();
      checks++; if (irr_clr !== 8'h00) begin failures++; $display("FAIL ack1_clr_pulse: got %h exp 00", irr_clr); end
      read_reg(3'b101);
      checks++; if (data_out !== 8'h04) begin failures++; $display("FAIL ack1_isr: got %h exp 04", data_out); end
      inta_n = 1'b0; tick();
      checks++; if (data_out !== 8'h22 || data_oe !== 1'b1) begin failures++; $display("FAIL ack2_vector: got %h/%b exp 22/1", data_out, data_oe); end
      inta_n = 1'b1; tick();
      checks++; if (data_oe !== 1'b0) begin failures++; $display("FAIL ack2_oe_drop: got %b exp 0", data_oe); end
   endtask

   task automatic test_nesting();
      irr = 8'h02; tick();
      checks++; if (int_out !== 1'b1) begin failures++; $display("FAIL nest_ir1_int: got %b exp 1", int_out); end
      do_ack(vec, voe);
      irr = 8'h00;
      checks++; if (vec !== 8'h21 || voe !== 1'b1) begin failures++; $display("FAIL nest_ir1_vec: got %h/%b exp 21/1", vec, voe); end
      write_cmd(3'd5, 8'h20);
      read_reg(3'b101);
      checks++; if (data_out !== 8'h04) begin failures++; $display("FAIL nest_eoi_isr: got %h exp 04", data_out); end
      irr = 8'h08; tick(); tick(); tick();
      checks++; if (int_out !== 1'b0) begin failures++; $display("FAIL nest_ir3_blocked: got %b exp 0", int_out); end
      write_cmd(3'd5, 8'h20);
      tick();
      checks++; if (int_out !== 1'b1) begin failures++; $display("FAIL nest_ir3_after_eoi: got %b exp 1", int_out); end
      do_ack(vec, voe);
      irr = 8'h00;
      checks++; if (vec !== 8'h23) begin failures++; $display("FAIL nest_ir3_vec: got %h exp 23", vec); end
      write_cmd(3'd5, 8'h63);
      read_reg(3'b101);
      checks++; if (data_out !== 8'h00) begin failures++; $display("FAIL nest_specific_eoi: got %h exp 00", data_out); end
   endtask

   task automatic test_aeoi();
      irr = 8'h01;
      init_pic(8'h03);
      tick();
      checks++; if (int_out !== 1'b1) begin failures++; $display("FAIL aeoi_int: got %b exp 1", int_out); end
      do_ack(vec, voe);
      irr = 8'h00;
      checks++; if (vec !== 8'h20) begin failures++; $display("FAIL aeoi_vec: got %h exp 20", vec); end
      read_reg(3'b101);
      checks++; if (data_out !== 8'h00) begin failures++; $display("FAIL aeoi_isr: got %h exp 00", data_out); end
   endtask

   task automatic test_mask_read();
      write_cmd(3'd4, 8'hFF);
      irr = 8'hFF; tick(); tick();
      checks++; if (int_out !== 1'b0) begin failures++; $display("FAIL mask_int: got %b exp 0", int_out); end
      read_reg(3'b011);
      checks++; if (data_out !== 8'hFF) begin failures++; $display("FAIL read_imr: got %h exp FF", data_out); end
      checks++; if (data_oe !== 1'b1) begin failures++; $display("FAIL read_oe: got %b exp 1", data_oe); end
      tick();
      checks++; if (data_oe !== 1'b0) begin failures++; $display("FAIL read_oe_one_cycle: got %b exp 0", data_oe); end
      irr = 8'h5A;
      read_reg(3'b000);
      checks++; if (data_out !== 8'h5A) begin failures++; $display("FAIL read_other_sel: got %h exp 5A", data_out); end
      read_reg(3'b111);
      checks++; if (data_out !== 8'h5A) begin failures++; $display("FAIL read_irr_111: got %h exp 5A", data_out); end
      irr = 8'h00;
      write_cmd(3'd4, 8'h00);
   endtask

   task automatic test_rotate();
      logic [7:0] exp_vec;
`ifdef PIC_ROTATE_EN
      exp_vec = 8'h24;
`else
      exp_vec = 8'h20;
`endif
      init_pic(8'h01);
      write_cmd(3'd5, 8'hC3);
      irr = 8'h11; tick();
      checks++; if (int_out !== 1'b1) begin failures++; $display("FAIL rot_int: got %b exp 1", int_out); end
      do_ack(vec, voe);
      irr = 8'h00;
      checks++; if (vec !== exp_vec) begin failures++; $display("FAIL rot_vec: got %h exp %h", vec, exp_vec); end
      write_cmd(3'd5, 8'h20);
   endtask

   task automatic test_reset_mid();
      init_pic(8'h01);
      irr = 8'h04; tick();
      checks++; if (int_out !== 1'b1) begin failures++; $display("FAIL mid_int: got %b exp 1", int_out); end
      inta_n = 1'b0; tick();
      inta_n = 1'b1; irr = 8'h00; tick();
      read_reg(3'b101);
      checks++; if (data_out !== 8'h04 || data_oe !== 1'b1) begin failures++; $display("FAIL mid_isr: got %h/%b exp 04/1", data_out, data_oe); end
      rst_n = 1'b0; #2;
      checks++; if (data_oe !== 1'b0) begin failures++; $display("FAIL mid_rst_oe: got %b exp 0", data_oe); end
      checks++; if (ready !== 1'b0) begin failures++; $display("FAIL mid_rst_ready: got %b exp 0", ready); end
      checks++; if (int_out !== 1'b0) begin failures++; $display("FAIL mid_rst_int: got %b exp 0", int_out); end
      rst_n = 1'b1; tick();
      read_reg(3'b101);
      checks++; if (data_out !== 8'h00) begin failures++; $display("FAIL mid_rst_isr: got %h exp 00", data_out); end
   endtask

   initial begin
      test_reset();
      test_init_ack();
      test_nesting();
      test_aeoi();
      test_mask_read();
      test_rotate();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
